// File: rtl/mem_write_monitor_pkg.sv
// -----------------------------------------------------------------------------
// mwmon_pkg
// Shared types and constants for the mem_write_monitor store-sequence checker.
//   state_e      : checker FSM states (IDLE, RUN, PASS, FAIL)
//   FC_*         : fail_code encodings reported on the fail_code output
//   is_verdict() : true when the FSM holds a final verdict (PASS or FAIL)
// -----------------------------------------------------------------------------
package mwmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_CFG      = 2'd3;

  function automatic logic is_verdict(input state_e s);
    return (s == PASS) || (s == FAIL);
  endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// -----------------------------------------------------------------------------
// mwmon_bus_if
// CPU data-memory write bus as seen by the store-sequence checker.
//   mem_write  : store strobe
//   data_adr   : store address (ADDR_W)
//   write_data : store data     (DATA_W)
// Modports:
//   master : the core driving the bus
//   slave  : the monitor observing it (inputs only)
// -----------------------------------------------------------------------------
interface mwmon_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              mem_write;
  logic [ADDR_W-1:0] data_adr;
  logic [DATA_W-1:0] write_data;

  modport master (
    output mem_write,
    output data_adr,
    output write_data
  );

  modport slave (
    input mem_write,
    input data_adr,
    input write_data
  );

endinterface

// File: rtl/mem_write_monitor_exp_table.sv
// -----------------------------------------------------------------------------
// mwmon_exp_table
// DEPTH-entry register file holding the expected (addr, data[, mask]) sequence.
// One synchronous write port, one asynchronous read port. Contents are not
// reset so a loaded table survives a reset and can be replayed.
// Optional feature macro: MWMON_MASK_EN (adds a per-entry data mask).
// Ports:
//   clk     in   clock
//   we_i    in   write strobe (already qualified by the caller)
//   widx_i  in   write index; indices >= DEPTH match no entry and are dropped
//   waddr_i in   expected address to store
//   wdata_i in   expected data to store
//   wmask_i in   data mask to store (MWMON_MASK_EN only)
//   ridx_i  in   read index; out-of-range reads return zero
//   raddr_o out  expected address at ridx_i
//   rdata_o out  expected data at ridx_i
//   rmask_o out  data mask at ridx_i (MWMON_MASK_EN only)
// -----------------------------------------------------------------------------
module mwmon_exp_table
  import mwmon_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  widx_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef MWMON_MASK_EN
  input  logic [DATA_W-1:0] wmask_i,
`endif
  input  logic [IDX_W-1:0]  ridx_i,
  output logic [ADDR_W-1:0] raddr_o,
`ifdef MWMON_MASK_EN
  output logic [DATA_W-1:0] rmask_o,
`endif
  output logic [DATA_W-1:0] rdata_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
`ifdef MWMON_MASK_EN
  logic [DATA_W-1:0] mask_q [DEPTH];
`endif

  // One write decoder per entry; an index >= DEPTH never decodes.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (we_i && (widx_i == IDX_W'(gi))) begin
          addr_q[gi] <= waddr_i;
          data_q[gi] <= wdata_i;
`ifdef MWMON_MASK_EN
          mask_q[gi] <= wmask_i;
`endif
        end
      end
    end
  endgenerate

  // Asynchronous read mux; match_cnt may equal DEPTH after the last match,
  // which falls through to the zero default.
  always_comb begin
    raddr_o = '0;
    rdata_o = '0;
`ifdef MWMON_MASK_EN
    rmask_o = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      if (ridx_i == IDX_W'(i)) begin
        raddr_o = addr_q[i];
        rdata_o = data_q[i];
`ifdef MWMON_MASK_EN
        rmask_o = mask_q[i];
`endif
      end
    end
  end

endmodule

// File: rtl/mem_write_monitor.sv
// -----------------------------------------------------------------------------
// mem_write_monitor
// Store-sequence checker on the CPU data-memory write bus. Each store (outside
// IGNORE_ADDR) must match the next entry of a loadable ordered table; the
// checker raises a sticky PASS or FAIL verdict (MISMATCH, TIMEOUT or CFG).
// Optional feature macro: MWMON_MASK_EN (per-entry data mask, port exp_mask).
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   synchronous active-low reset (table contents retained)
//   bus         in   mwmon_bus_if.slave: mem_write / data_adr / write_data
//   exp_we      in   table write strobe, honoured in IDLE only
//   exp_idx     in   table entry index
//   exp_addr    in   expected address for the entry
//   exp_data    in   expected data for the entry
//   exp_mask    in   data compare mask for the entry (MWMON_MASK_EN only)
//   num_expect  in   number of entries to check, sampled on start
//   start       in   IDLE -> RUN request
//   clear       in   PASS/FAIL -> IDLE request
//   done        out  verdict reached
//   pass        out  verdict is PASS
//   fail_code   out  FC_NONE / FC_MISMATCH / FC_TIMEOUT / FC_CFG
//   match_cnt   out  stores matched so far
//   cap_addr    out  address of the mismatching store
//   cap_data    out  data of the mismatching store
// -----------------------------------------------------------------------------
module mem_write_monitor
  import mwmon_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter int              DEPTH       = 8,
  parameter int              TIMEOUT     = 1024,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = 96,
  localparam int             IDX_W       = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  mwmon_bus_if.slave        bus,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
`ifdef MWMON_MASK_EN
  input  logic [DATA_W-1:0] exp_mask,
`endif
  input  logic [IDX_W-1:0]  num_expect,
  input  logic              start,
  input  logic              clear,
  output logic              done,
  output logic              pass,
  output logic [1:0]        fail_code,
  output logic [IDX_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] cap_addr,
  output logic [DATA_W-1:0] cap_data
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q,      state_d;
  logic [1:0]        fail_code_q,  fail_code_d;
  logic [IDX_W-1:0]  match_cnt_q,  match_cnt_d;
  logic [IDX_W-1:0]  num_expect_q, num_expect_d;
  logic [ADDR_W-1:0] cap_addr_q,   cap_addr_d;
  logic [DATA_W-1:0] cap_data_q,   cap_data_d;
  logic [TW-1:0]     timer_q,      timer_d;

  logic [ADDR_W-1:0] ent_addr;
  logic [DATA_W-1:0] ent_data;
`ifdef MWMON_MASK_EN
  logic [DATA_W-1:0] ent_mask;
`endif
  logic              data_eq;
  logic              entry_hit;
  logic              store_seen;
  logic              last_entry;
  logic              cfg_bad;
  logic [TW-1:0]     timer_inc;
  logic [IDX_W-1:0]  match_inc;

  // The table is frozen outside IDLE so a running check cannot be disturbed.
  mwmon_exp_table #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_table (
    .clk     (clk),
    .we_i    (exp_we && (state_q == IDLE)),
    .widx_i  (exp_idx),
    .waddr_i (exp_addr),
    .wdata_i (exp_data),
`ifdef MWMON_MASK_EN
    .wmask_i (exp_mask),
    .rmask_o (ent_mask),
`endif
    .ridx_i  (match_cnt_q),
    .raddr_o (ent_addr),
    .rdata_o (ent_data)
  );

`ifdef MWMON_MASK_EN
  assign data_eq = ((bus.write_data ^ ent_data) & ent_mask) == '0;
`else
  assign data_eq = (bus.write_data == ent_data);
`endif

  // Stores to the scratch address are invisible to the checker.
  assign store_seen = bus.mem_write && (bus.data_adr != IGNORE_ADDR);
  assign entry_hit  = (bus.data_adr == ent_addr) && data_eq;
  assign match_inc  = match_cnt_q + IDX_W'(1);
  assign last_entry = (match_inc == num_expect_q);
  assign timer_inc  = timer_q + TW'(1);
  assign cfg_bad    = (num_expect == '0) || (num_expect > IDX_W'(DEPTH));

  always_comb begin
    state_d      = state_q;
    fail_code_d  = fail_code_q;
    match_cnt_d  = match_cnt_q;
    num_expect_d = num_expect_q;
    cap_addr_d   = cap_addr_q;
    cap_data_d   = cap_data_q;
    timer_d      = timer_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            state_d     = FAIL;
            fail_code_d = FC_CFG;
          end else begin
            state_d      = RUN;
            num_expect_d = num_expect;
            match_cnt_d  = '0;
            timer_d      = '0;
          end
        end
      end

      RUN: begin
        if (store_seen) begin
          // A store resolves this cycle, so timer expiry cannot also fire.
          if (entry_hit) begin
            match_cnt_d = match_inc;
            timer_d     = '0;
            if (last_entry) begin
              state_d = PASS;
            end
          end else begin
            state_d     = FAIL;
            fail_code_d = FC_MISMATCH;
            cap_addr_d  = bus.data_adr;
            cap_data_d  = bus.write_data;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TW'(TIMEOUT)) begin
            state_d     = FAIL;
            fail_code_d = FC_TIMEOUT;
          end
        end
      end

      PASS, FAIL: begin
        if (clear) begin
          state_d      = IDLE;
          fail_code_d  = FC_NONE;
          match_cnt_d  = '0;
          num_expect_d = '0;
          cap_addr_d   = '0;
          cap_data_d   = '0;
          timer_d      = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      fail_code_q  <= FC_NONE;
      match_cnt_q  <= '0;
      num_expect_q <= '0;
      cap_addr_q   <= '0;
      cap_data_q   <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      fail_code_q  <= fail_code_d;
      match_cnt_q  <= match_cnt_d;
      num_expect_q <= num_expect_d;
      cap_addr_q   <= cap_addr_d;
      cap_data_q   <= cap_data_d;
      timer_q      <= timer_d;
    end
  end

  assign done      = is_verdict(state_q);
  assign pass      = (state_q == PASS);
  assign fail_code = fail_code_q;
  assign match_cnt = match_cnt_q;
  assign cap_addr  = cap_addr_q;
  assign cap_data  = cap_data_q;

endmodule

// File: tb/tb_mem_write_monitor.sv
// -----------------------------------------------------------------------------
// tb_mem_write_monitor
// Directed stimulus pushes expected outputs into a scoreboard queue; a monitor
// process pops an entry either immediately (snapshot) or on the rising edge of
// done (verdict) and compares every output field.
// Build options: MWMON_MASK_EN selects the masked-compare expectation.
// -----------------------------------------------------------------------------
module tb_mem_write_monitor;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 50;
  localparam int IDX_W   = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              exp_we;
  logic [IDX_W-1:0]  exp_idx;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic [DATA_W-1:0] exp_mask;
  logic [IDX_W-1:0]  num_expect;
  logic              start;
  logic              clear;
  logic              done;
  logic              pass;
  logic [1:0]        fail_code;
  logic [IDX_W-1:0]  match_cnt;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;

  mwmon_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_write_monitor #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .TIMEOUT     (TIMEOUT),
    .IGNORE_ADDR (32'd96)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .exp_we     (exp_we),
    .exp_idx    (exp_idx),
    .exp_addr   (exp_addr),
    .exp_data   (exp_data),
`ifdef MWMON_MASK_EN
    .exp_mask   (exp_mask),
`endif
    .num_expect (num_expect),
    .start      (start),
    .clear      (clear),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .match_cnt  (match_cnt),
    .cap_addr   (cap_addr),
    .cap_data   (cap_data)
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  typedef struct {
    string       name;
    bit          on_done;  // 1: compare at rising done; 0: compare at next negedge
    int          cyc;      // required cycle_cnt at compare time, -1 = don't care
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic [3:0]  mc;
    logic [31:0] ca;
    logic [31:0] cd;
  } exp_t;

  exp_t sb_q[$];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic chk(input string nm, input string field,
                     input logic [31:0] got, input logic [31:0] req);
    n_total++;
    if (got !== req)
      $display("FAIL %s.%s got=0x%0h required=0x%0h", nm, field, got, req);
    else
      n_passed++;
  endtask

  function automatic void push_exp(input string nm, input bit od, input int cyc,
                                   input bit d, input bit p, input int fc, input int mc,
                                   input logic [31:0] ca, input logic [31:0] cd);
    exp_t e;
    e.name = nm; e.on_done = od; e.cyc = cyc;
    e.done = d; e.pass = p; e.fc = 2'(fc); e.mc = 4'(mc); e.ca = ca; e.cd = cd;
    sb_q.push_back(e);
  endfunction

  // Monitor: decoupled from stimulus, samples on the falling edge.
  initial begin : monitor
    logic done_prev;
    logic rise;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      rise = done && !done_prev;
      if (sb_q.size() != 0 && (!sb_q[0].on_done || rise)) begin
        e = sb_q.pop_front();
        $display("txn %-12s cyc=%0d done=%0b pass=%0b fc=%0d mc=%0d cap=(%0h,%0h)",
                 e.name, cycle_cnt, done, pass, fail_code, match_cnt, cap_addr, cap_data);
        chk(e.name, "done",      32'(done),      32'(e.done));
        chk(e.name, "pass",      32'(pass),      32'(e.pass));
        chk(e.name, "fail_code", 32'(fail_code), 32'(e.fc));
        chk(e.name, "match_cnt", 32'(match_cnt), 32'(e.mc));
        chk(e.name, "cap_addr",  cap_addr,       e.ca);
        chk(e.name, "cap_data",  cap_data,       e.cd);
        if (e.cyc >= 0) chk(e.name, "cycle", 32'(cycle_cnt), 32'(e.cyc));
      end else if (rise) begin
        n_total++;
        $display("FAIL unexpected_done got done=1 fc=%0d mc=%0d required no verdict",
                 fail_code, match_cnt);
      end
      done_prev = done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      n_total++;
      $display("FAIL %s_wait got pending=%0d required pending=0", nm, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.mem_write  = 1'b1;
    bus.data_adr   = a;
    bus.write_data = d;
    tick();
    bus.mem_write  = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] m);
    exp_we   = 1'b1;
    exp_idx  = 4'(idx);
    exp_addr = a;
    exp_data = d;
    exp_mask = m;
    tick();
    exp_we   = 1'b0;
  endtask

  task automatic do_start(input int n);
    num_expect = 4'(n);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin : stimulus
    int c0;
    reset_n        = 1'b0;
    exp_we         = 1'b0;
    exp_idx        = '0;
    exp_addr       = '0;
    exp_data       = '0;
    exp_mask       = '1;
    num_expect     = '0;
    start          = 1'b0;
    clear          = 1'b0;
    bus.mem_write  = 1'b0;
    bus.data_adr   = '0;
    bus.write_data = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    push_exp("reset", 0, -1, 0, 0, 0, 0, 0, 0);
    drain("reset");

    // 1: ignored scratch store, then a single matching store
    load(0, 32'd100, 32'd25, 32'hFFFF_FFFF);
    do_start(1);
    store(32'd96, 32'd7);
    push_exp("t1_ignore", 0, -1, 0, 0, 0, 0, 0, 0);
    drain("t1_ignore");
    push_exp("t1_pass", 1, -1, 1, 1, 0, 1, 0, 0);
    store(32'd100, 32'd25);
    drain("t1_pass");
    store(32'd104, 32'd1);
    push_exp("t1_sticky", 0, -1, 1, 1, 0, 1, 0, 0);
    drain("t1_sticky");
    do_clear();
    push_exp("t1_clear", 0, -1, 0, 0, 0, 0, 0, 0);
    drain("t1_clear");

    // 2: wrong address -> MISMATCH with capture
    do_start(1);
    push_exp("t2_mismatch", 1, -1, 1, 0, 1, 0, 32'd104, 32'd25);
    store(32'd104, 32'd25);
    drain("t2_mismatch");
    do_clear();

    // 3: no stores -> TIMEOUT exactly TIMEOUT cycles after RUN entry
    do_start(1);
    c0 = cycle_cnt;
    push_exp("t3_timeout", 1, c0 + TIMEOUT, 1, 0, 2, 0, 0, 0);
    drain("t3_timeout");
    do_clear();

    // 4: reset mid-run, then replay from the retained table
    load(0, 32'd200, 32'h11, 32'hFFFF_FFFF);
    load(1, 32'd204, 32'h22, 32'hFFFF_FFFF);
    load(2, 32'd208, 32'h33, 32'hFFFF_FFFF);
    do_start(3);
    store(32'd200, 32'h11);
    store(32'd96,  32'h5);
    store(32'd204, 32'h22);
    push_exp("t4_partial", 0, -1, 0, 0, 0, 2, 0, 0);
    drain("t4_partial");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    push_exp("t4_reset", 0, -1, 0, 0, 0, 0, 0, 0);
    drain("t4_reset");
    do_start(3);
    push_exp("t4_replay", 1, -1, 1, 1, 0, 3, 0, 0);
    store(32'd200, 32'h11);
    store(32'd204, 32'h22);
    store(32'd208, 32'h33);
    drain("t4_replay");
    do_clear();

    // 5: num_expect = 0 -> CFG on the start edge
    do_start(0);
    c0 = cycle_cnt;
    push_exp("t5_cfg0", 1, c0, 1, 0, 3, 0, 0, 0);
    drain("t5_cfg0");
    do_clear();
    push_exp("t5_clear", 0, -1, 0, 0, 0, 0, 0, 0);
    drain("t5_clear");

    // num_expect > DEPTH -> CFG
    do_start(DEPTH + 1);
    c0 = cycle_cnt;
    push_exp("t5_cfg9", 1, c0, 1, 0, 3, 0, 0, 0);
    drain("t5_cfg9");
    do_clear();

    // table writes during RUN must not take effect
    load(0, 32'd100, 32'd25, 32'hFFFF_FFFF);
    do_start(1);
    load(0, 32'd300, 32'd1, 32'hFFFF_FFFF);
    push_exp("t7_frozen", 1, -1, 1, 1, 0, 1, 0, 0);
    store(32'd100, 32'd25);
    drain("t7_frozen");
    do_clear();

    // 6: masked compare of the low byte
    load(0, 32'd100, 32'h19, 32'h0000_00FF);
    do_start(1);
`ifdef MWMON_MASK_EN
    push_exp("t6_mask", 1, -1, 1, 1, 0, 1, 0, 0);
`else
    push_exp("t6_exact", 1, -1, 1, 0, 1, 0, 32'd100, 32'hABCD_0019);
`endif
    store(32'd100, 32'hABCD_0019);
    drain("t6_mask");
    do_clear();
    tick();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
